// File: rtl/up_counter4.sv
// up_counter4: WIDTH-bit synchronous up-counter with parallel load.
// Priority on each rising clk edge: rst, then load, then increment.
// The count wraps modulo 2^WIDTH with no carry output. It is driven straight
// from the state register, so no input reaches count combinationally.
module up_counter4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // State register: synchronous reset wins over load, and load wins over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= a;
    end else begin
      count <= count + ONE;
    end
  end

endmodule

// File: tb/tb_up_counter4.sv
// tb_up_counter4: directed vector table plus hand-written sequences for
// between-edge reset and a free-running reference comparison.
module tb_up_counter4;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] a;
  logic [3:0] count;

  int n_checks;
  int n_errors;

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] a;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  up_counter4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .a     (a),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: count=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic r, input logic l, input logic [3:0] av,
                                  input logic [3:0] e, input string n);
    vec_t v;
    v.rst  = r;
    v.load = l;
    v.a    = av;
    v.exp  = e;
    v.name = n;
    vecs.push_back(v);
  endfunction

  // Drive inputs on the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic r, input logic l, input logic [3:0] av);
    @(negedge clk);
    rst  = r;
    load = l;
    a    = av;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] model;
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b0;
    load = 1'b0;
    a    = 4'd0;

    // reset, then free counting with a=7 ignored
    add_vec(1, 0, 4'd7, 4'd0, "reset");
    add_vec(0, 0, 4'd7, 4'd1, "post_reset_1");
    add_vec(0, 0, 4'd7, 4'd2, "post_reset_2");
    add_vec(0, 0, 4'd7, 4'd3, "post_reset_3");
    // load 0, then count 1..15 with a=7 ignored
    add_vec(0, 1, 4'd0, 4'd0, "load_0");
    for (int i = 1; i <= 15; i++) add_vec(0, 0, 4'd7, 4'(i), "count_up");
    // wrap-around
    add_vec(0, 1, 4'd14, 4'd14, "load_14");
    add_vec(0, 0, 4'd0, 4'd15, "wrap_15");
    add_vec(0, 0, 4'd0, 4'd0, "wrap_0");
    add_vec(0, 0, 4'd0, 4'd1, "wrap_1");
    // count up to 5, then a one-edge load of 11
    add_vec(0, 0, 4'd0, 4'd2, "to5_2");
    add_vec(0, 0, 4'd0, 4'd3, "to5_3");
    add_vec(0, 0, 4'd0, 4'd4, "to5_4");
    add_vec(0, 0, 4'd0, 4'd5, "to5_5");
    add_vec(0, 1, 4'd11, 4'd11, "mid_load_11");
    add_vec(0, 0, 4'd0, 4'd12, "after_load_12");
    add_vec(0, 0, 4'd0, 4'd13, "after_load_13");
    // load held for three edges, then with a changing while load stays high
    add_vec(0, 1, 4'd3, 4'd3, "hold_load_1");
    add_vec(0, 1, 4'd3, 4'd3, "hold_load_2");
    add_vec(0, 1, 4'd3, 4'd3, "hold_load_3");
    add_vec(0, 0, 4'd3, 4'd4, "hold_release");
    add_vec(0, 1, 4'd6, 4'd6, "track_a_6");
    add_vec(0, 1, 4'd8, 4'd8, "track_a_8");
    add_vec(0, 0, 4'd0, 4'd9, "reach_9");
    // reset and load together at count 9: reset wins
    add_vec(1, 1, 4'd12, 4'd0, "rst_beats_load");
    add_vec(0, 0, 4'd12, 4'd1, "after_rst_1");
    add_vec(0, 0, 4'd12, 4'd2, "after_rst_2");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].a);
      check(vecs[i].name, count, vecs[i].exp);
    end

    // rst raised between edges: no change until the next rising edge
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_no_edge", count, 4'd2);
    @(posedge clk);
    #1;
    check("rst_at_edge", count, 4'd0);
    step(0, 0, 4'd5);
    check("rst_resume", count, 4'd1);

    // a toggled while load is low has no effect
    @(negedge clk);
    a = 4'd15;
    #1;
    a = 4'd9;
    @(posedge clk);
    #1;
    check("a_ignored", count, 4'd2);

    // free run for 300 ns after a reset, compared with a reference count
    step(1, 0, 4'd0);
    check("long_reset", count, 4'd0);
    model = 4'd0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 4'(i));
      model = model + 4'd1;
      check("long_run", count, model);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
